// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the core pipeline (master) and its stall/flush controller (slave).
// The pipeline drives ready and the requests; the controller returns per-stage controls and counters.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(NUM_STAGES)
);
  logic                  rdy;
  logic [NUM_STAGES-1:0] stall_req_i;
  logic                  flush_req_i;
  logic [SEL_W-1:0]      flush_stage_i;
  logic                  perf_clr_i;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] bubble_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  flush_busy_o;
  logic [CNT_W-1:0]      stall_cycles_o;
  logic [CNT_W-1:0]      flush_cnt_o;
  logic                  wdt_timeout_o;

  modport master (
    output rdy, stall_req_i, flush_req_i, flush_stage_i, perf_clr_i,
    input  stall_o, bubble_o, flush_o, flush_busy_o, stall_cycles_o, flush_cnt_o, wdt_timeout_o
  );

  modport slave (
    input  rdy, stall_req_i, flush_req_i, flush_stage_i, perf_clr_i,
    output stall_o, bubble_o, flush_o, flush_busy_o, stall_cycles_o, flush_cnt_o, wdt_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller for NUM_STAGES stages (0 = youngest).
// Stall/bubble decode is combinational; flush windows, watchdog and perf counters are registered.
module pipe_ctrl_gen #(
  parameter int NUM_STAGES = 5,
  parameter int FLUSH_LEN  = 2,
  parameter int WDT_LIMIT  = 1024,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int WD_W = $clog2(WDT_LIMIT + 1);
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_LEN - 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(WDT_LIMIT);

  function automatic logic [NUM_STAGES-1:0] below_mask(input logic [SEL_W-1:0] s);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_STAGES; j++) m[j] = (j < int'(s));
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [FL_W-1:0]       fcnt_q, fcnt_d;
  logic [SEL_W-1:0]      ftgt_q, ftgt_d;
  logic [WD_W-1:0]       wdt_q, wdt_d;
  logic                  wdt_to_q, wdt_to_d;
  logic [CNT_W-1:0]      stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic                  any_stall;
  logic                  stage_ok;
  logic                  flush_accept;
  logic                  win_active;
  logic [NUM_STAGES-1:0] stall_vec, bubble_vec, flush_vec;

  // Request decode and per-stage control outputs
  always_comb begin
    stall_vec  = '0;
    bubble_vec = '0;
    any_stall  = 1'b0;
    // Walk from the oldest stage down so everything younger than the first requester is held.
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (bus.stall_req_i[j] && !any_stall && (j < NUM_STAGES - 1)) bubble_vec[j] = 1'b1;
      any_stall    = any_stall | bus.stall_req_i[j];
      stall_vec[j] = any_stall;
    end

    stage_ok     = (bus.flush_stage_i != '0) && (int'(bus.flush_stage_i) < NUM_STAGES);
    flush_accept = bus.flush_req_i && bus.rdy && stage_ok;
    win_active   = (fcnt_q != '0);
    flush_vec    = (win_active   ? below_mask(ftgt_q)            : '0) |
                   (flush_accept ? below_mask(bus.flush_stage_i) : '0);

    if (rst) begin
      bus.stall_o  = '0;
      bus.bubble_o = '0;
      bus.flush_o  = '0;
    end else if (!bus.rdy) begin
      bus.stall_o  = '1;
      bus.bubble_o = '0;
      bus.flush_o  = '0;
    end else begin
      bus.stall_o  = stall_vec;
      bus.bubble_o = bubble_vec;
      bus.flush_o  = flush_vec;
    end

    bus.flush_busy_o   = win_active;
    bus.stall_cycles_o = stall_cyc_q;
    bus.flush_cnt_o    = flush_cnt_q;
    bus.wdt_timeout_o  = wdt_to_q;
  end

  // Next-state: everything holds while the pipeline is frozen, except an explicit counter clear
  always_comb begin
    fcnt_d      = fcnt_q;
    ftgt_d      = ftgt_q;
    wdt_d       = wdt_q;
    wdt_to_d    = wdt_to_q;
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;

    if (bus.rdy) begin
      if (flush_accept) begin
        fcnt_d      = FL_RELOAD;
        ftgt_d      = bus.flush_stage_i;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (win_active) begin
        fcnt_d = fcnt_q - FL_W'(1);
      end

      if (any_stall) begin
        stall_cyc_d = sat_inc(stall_cyc_q);
        wdt_d       = (wdt_q == WD_MAX) ? wdt_q : wdt_q + WD_W'(1);
      end else begin
        wdt_d = '0;
      end
      wdt_to_d = wdt_to_q | (wdt_d == WD_MAX);
    end

    if (bus.perf_clr_i) begin
      stall_cyc_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      ftgt_q      <= '0;
      wdt_q       <= '0;
      wdt_to_q    <= 1'b0;
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      ftgt_q      <= ftgt_d;
      wdt_q       <= wdt_d;
      wdt_to_q    <= wdt_to_d;
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: 5 stages, 3-cycle flush window, watchdog limit 8, 4-bit counters.
module tb_pipe_ctrl_gen;
  localparam int NS = 5;
  localparam int FL = 3;
  localparam int WL = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pipe_ctrl_gen #(
    .NUM_STAGES(NS), .FLUSH_LEN(FL), .WDT_LIMIT(WL), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.stall_req_i = 5'b11111;
    bus.flush_req_i = 1'b1;
    bus.flush_stage_i = 3'd2;
    bus.perf_clr_i = 1'b0;
    #2;
    n_total++; if (bus.stall_o !== 5'b00000) $display("FAIL rst_stall got %b want %b", bus.stall_o, 5'b00000); else n_pass++;
    n_total++; if (bus.flush_o !== 5'b00000) $display("FAIL rst_flush got %b want %b", bus.flush_o, 5'b00000); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.stall_cycles_o !== 4'd0) $display("FAIL rst_stallcyc got %0d want 0", bus.stall_cycles_o); else n_pass++;
    n_total++; if (bus.flush_busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.flush_busy_o); else n_pass++;
    rst = 1'b0;
    bus.stall_req_i = '0;
    bus.flush_req_i = 1'b0;
    bus.flush_stage_i = '0;
    for (int i = 0; i < 10; i++) tick();
    n_total++; if (bus.stall_cycles_o !== 4'd0) $display("FAIL idle_stallcyc got %0d want 0", bus.stall_cycles_o); else n_pass++;
    n_total++; if ({bus.stall_o, bus.bubble_o, bus.flush_o} !== 15'd0) $display("FAIL idle_ctrl got %b want 0", {bus.stall_o, bus.bubble_o, bus.flush_o}); else n_pass++;
    n_total++; if ({bus.flush_cnt_o, bus.wdt_timeout_o, bus.flush_busy_o} !== 6'd0) $display("FAIL idle_regs got %b want 0", {bus.flush_cnt_o, bus.wdt_timeout_o, bus.flush_busy_o}); else n_pass++;
  endtask

  task automatic test_stall();
    bus.stall_req_i = 5'b01010; #2;
    n_total++; if (bus.stall_o !== 5'b01111) $display("FAIL stall_a got %b want %b", bus.stall_o, 5'b01111); else n_pass++;
    n_total++; if (bus.bubble_o !== 5'b01000) $display("FAIL bubble_a got %b want %b", bus.bubble_o, 5'b01000); else n_pass++;
    tick();
    bus.stall_req_i = 5'b10000; #2;
    n_total++; if (bus.stall_o !== 5'b11111) $display("FAIL stall_b got %b want %b", bus.stall_o, 5'b11111); else n_pass++;
    n_total++; if (bus.bubble_o !== 5'b00000) $display("FAIL bubble_b got %b want %b", bus.bubble_o, 5'b00000); else n_pass++;
    tick();
    bus.stall_req_i = 5'b00101; #2;
    n_total++; if (bus.stall_o !== 5'b00111) $display("FAIL stall_c got %b want %b", bus.stall_o, 5'b00111); else n_pass++;
    n_total++; if (bus.bubble_o !== 5'b00100) $display("FAIL bubble_c got %b want %b", bus.bubble_o, 5'b00100); else n_pass++;
    tick();
    bus.stall_req_i = '0; #2;
    n_total++; if (bus.stall_cycles_o !== 4'd3) $display("FAIL stall_count got %0d want 3", bus.stall_cycles_o); else n_pass++;
    n_total++; if (bus.stall_o !== 5'b00000) $display("FAIL stall_none got %b want 0", bus.stall_o); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    bus.flush_req_i = 1'b1; bus.flush_stage_i = 3'd2; bus.stall_req_i = 5'b00100; #2;
    n_total++; if (bus.flush_o !== 5'b00011) $display("FAIL flush_c1 got %b want %b", bus.flush_o, 5'b00011); else n_pass++;
    n_total++; if (bus.stall_o !== 5'b00111 || bus.bubble_o !== 5'b00100) $display("FAIL flush_stall got %b/%b want 00111/00100", bus.stall_o, bus.bubble_o); else n_pass++;
    n_total++; if (bus.flush_busy_o !== 1'b0) $display("FAIL busy_c1 got %b want 0", bus.flush_busy_o); else n_pass++;
    tick();
    bus.flush_req_i = 1'b0; bus.stall_req_i = '0; #2;
    n_total++; if (bus.flush_o !== 5'b00011 || bus.flush_busy_o !== 1'b1) $display("FAIL flush_c2 got %b busy %b want 00011 busy 1", bus.flush_o, bus.flush_busy_o); else n_pass++;
    tick();
    n_total++; if (bus.flush_o !== 5'b00011 || bus.flush_busy_o !== 1'b1) $display("FAIL flush_c3 got %b busy %b want 00011 busy 1", bus.flush_o, bus.flush_busy_o); else n_pass++;
    tick();
    n_total++; if (bus.flush_o !== 5'b00000 || bus.flush_busy_o !== 1'b0) $display("FAIL flush_end got %b busy %b want 0 busy 0", bus.flush_o, bus.flush_busy_o); else n_pass++;
    n_total++; if (bus.flush_cnt_o !== 4'd1) $display("FAIL flush_cnt1 got %0d want 1", bus.flush_cnt_o); else n_pass++;
    bus.flush_req_i = 1'b1; bus.flush_stage_i = 3'd0; #2;
    n_total++; if (bus.flush_o !== 5'b00000) $display("FAIL flush_s0 got %b want 0", bus.flush_o); else n_pass++;
    tick();
    bus.flush_stage_i = 3'd5; #2;
    n_total++; if (bus.flush_o !== 5'b00000) $display("FAIL flush_s5 got %b want 0", bus.flush_o); else n_pass++;
    tick();
    bus.flush_req_i = 1'b0; bus.flush_stage_i = '0; #2;
    n_total++; if (bus.flush_cnt_o !== 4'd1 || bus.flush_busy_o !== 1'b0) $display("FAIL flush_bad_cnt got %0d busy %b want 1 busy 0", bus.flush_cnt_o, bus.flush_busy_o); else n_pass++;
  endtask

  task automatic test_reflush_freeze();
    bus.flush_req_i = 1'b1; bus.flush_stage_i = 3'd2; #2;
    n_total++; if (bus.flush_o !== 5'b00011) $display("FAIL reflush_a got %b want %b", bus.flush_o, 5'b00011); else n_pass++;
    tick();
    bus.flush_stage_i = 3'd3; #2;
    n_total++; if (bus.flush_o !== 5'b00111) $display("FAIL reflush_b got %b want %b", bus.flush_o, 5'b00111); else n_pass++;
    tick();
    bus.flush_req_i = 1'b0; bus.flush_stage_i = '0; #2;
    n_total++; if (bus.flush_o !== 5'b00111 || bus.flush_busy_o !== 1'b1) $display("FAIL reflush_c got %b busy %b want 00111 busy 1", bus.flush_o, bus.flush_busy_o); else n_pass++;
    tick();
    bus.rdy = 1'b0; bus.flush_req_i = 1'b1; bus.flush_stage_i = 3'd1; bus.stall_req_i = 5'b00001; #2;
    n_total++; if (bus.stall_o !== 5'b11111 || bus.flush_o !== 5'b00000 || bus.bubble_o !== 5'b00000) $display("FAIL freeze got s%b f%b b%b want s11111 f0 b0", bus.stall_o, bus.flush_o, bus.bubble_o); else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    bus.rdy = 1'b1; bus.flush_req_i = 1'b0; bus.flush_stage_i = '0; bus.stall_req_i = '0; #2;
    n_total++; if (bus.flush_o !== 5'b00111 || bus.flush_busy_o !== 1'b1) $display("FAIL resume got %b busy %b want 00111 busy 1", bus.flush_o, bus.flush_busy_o); else n_pass++;
    tick();
    n_total++; if (bus.flush_o !== 5'b00000 || bus.flush_busy_o !== 1'b0) $display("FAIL resume_end got %b busy %b want 0 busy 0", bus.flush_o, bus.flush_busy_o); else n_pass++;
    n_total++; if (bus.flush_cnt_o !== 4'd3) $display("FAIL reflush_cnt got %0d want 3", bus.flush_cnt_o); else n_pass++;
    n_total++; if (bus.stall_cycles_o !== 4'd4) $display("FAIL freeze_stallcyc got %0d want 4", bus.stall_cycles_o); else n_pass++;
  endtask

  task automatic test_watchdog();
    bus.stall_req_i = 5'b00001;
    for (int i = 0; i < 7; i++) tick();
    n_total++; if (bus.wdt_timeout_o !== 1'b0) $display("FAIL wdt_7 got %b want 0", bus.wdt_timeout_o); else n_pass++;
    bus.stall_req_i = '0;
    tick();
    n_total++; if (bus.wdt_timeout_o !== 1'b0) $display("FAIL wdt_drop got %b want 0", bus.wdt_timeout_o); else n_pass++;
    bus.stall_req_i = 5'b00001;
    for (int i = 0; i < 7; i++) tick();
    n_total++; if (bus.wdt_timeout_o !== 1'b0) $display("FAIL wdt_pre8 got %b want 0", bus.wdt_timeout_o); else n_pass++;
    tick();
    n_total++; if (bus.wdt_timeout_o !== 1'b1) $display("FAIL wdt_8 got %b want 1", bus.wdt_timeout_o); else n_pass++;
    bus.stall_req_i = '0;
    tick();
    n_total++; if (bus.wdt_timeout_o !== 1'b1) $display("FAIL wdt_sticky got %b want 1", bus.wdt_timeout_o); else n_pass++;
    n_total++; if (bus.stall_cycles_o !== 4'd15) $display("FAIL stallcyc_sat1 got %0d want 15", bus.stall_cycles_o); else n_pass++;
  endtask

  task automatic test_counters();
    bus.perf_clr_i = 1'b1; bus.stall_req_i = 5'b00001;
    tick();
    n_total++; if (bus.stall_cycles_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) $display("FAIL perf_clr got %0d/%0d want 0/0", bus.stall_cycles_o, bus.flush_cnt_o); else n_pass++;
    bus.perf_clr_i = 1'b0;
    tick();
    tick();
    n_total++; if (bus.stall_cycles_o !== 4'd2) $display("FAIL perf_resume got %0d want 2", bus.stall_cycles_o); else n_pass++;
    for (int i = 0; i < 18; i++) tick();
    n_total++; if (bus.stall_cycles_o !== 4'd15) $display("FAIL stallcyc_sat20 got %0d want 15", bus.stall_cycles_o); else n_pass++;
    bus.stall_req_i = '0;
    n_total++; if (bus.wdt_timeout_o !== 1'b1) $display("FAIL wdt_hold got %b want 1", bus.wdt_timeout_o); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (bus.wdt_timeout_o !== 1'b0 || bus.stall_cycles_o !== 4'd0) $display("FAIL wdt_rst got %b/%0d want 0/0", bus.wdt_timeout_o, bus.stall_cycles_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_reflush_freeze();
    test_watchdog();
    test_counters();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
